// File: rtl/transmissor_ascii_param_pkg.sv
// Shared types and helpers for the multi-character serial transmitter.
package transmissor_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  localparam int PARIDADE_PAR   = 0;
  localparam int PARIDADE_IMPAR = 1;

  // Line bits per character: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int paridade_en,
                                    input int stop_bits);
    return 1 + data_bits + paridade_en + stop_bits;
  endfunction

  // Parity over a zero-extended character; impar=1 gives odd parity.
  function automatic logic calc_paridade(input logic [7:0] c, input logic impar);
    return (^c) ^ impar;
  endfunction

endpackage

// File: rtl/transmissor_ascii_param_if.sv
// Character-block bus between the producer and the serial transmitter.
interface transmissor_ascii_param_if #(
  parameter int NUM_CHARS = 8,
  parameter int DATA_BITS = 7
) ();
  localparam int CNT_W = $clog2(NUM_CHARS + 1);
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  // Request/completion handshake: iniciar is a request that is taken only
  // while the transmitter is idle (ocupado low and no pronto pulse); on that
  // edge dados_ascii/num_caracteres are captured. A request while busy is
  // dropped, not queued. pronto pulses once when the block is finished.
  logic                           iniciar;
  logic [NUM_CHARS*DATA_BITS-1:0] dados_ascii;
  logic [CNT_W-1:0]               num_caracteres;
  logic                           saida_serial;
  logic                           ocupado;
  logic                           pronto;
  logic [IDX_W-1:0]               indice_caractere;
  transmissor_pkg::estado_t       estado;

  modport master (
    output iniciar, dados_ascii, num_caracteres,
    input  saida_serial, ocupado, pronto, indice_caractere, estado
  );

  modport slave (
    input  iniciar, dados_ascii, num_caracteres,
    output saida_serial, ocupado, pronto, indice_caractere, estado
  );
endinterface

// File: rtl/transmissor_ascii_param_contador.sv
// Generic mod-M counter; fim marks the last count of each period.
module contador_m #(
  parameter int M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);
  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] conta;

  // Count 0..M-1 while enabled; clr forces a reload to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conta <= '0;
    end else if (clr) begin
      conta <= '0;
    end else if (en) begin
      conta <= (conta == W'(M - 1)) ? '0 : conta + W'(1);
    end
  end

  assign fim = en && (conta == W'(M - 1));
endmodule

// File: rtl/transmissor_ascii_param.sv
// Multi-character asynchronous serial transmitter with parity and stop options.
module transmissor_ascii_param
  import transmissor_pkg::*;
#(
  parameter int NUM_CHARS    = 8,
  parameter int DATA_BITS    = 7,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 2
) (
  input logic                      clock,
  input logic                      reset,
  transmissor_ascii_param_if.slave bus
);
  localparam int   CNT_W = $clog2(NUM_CHARS + 1);
  localparam int   IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int   BIT_W = $clog2(DATA_BITS);
  localparam logic IMPAR = (PARITY_ODD == PARIDADE_IMPAR);

  estado_t                        estado;
  logic [NUM_CHARS*DATA_BITS-1:0] buffer;
  logic [DATA_BITS-1:0]           shift;
  logic                           paridade;
  logic [CNT_W-1:0]               total;
  logic [IDX_W-1:0]               indice;
  logic [BIT_W-1:0]               bit_cnt;
  logic                           stop_cnt;
  logic                           saida;
  logic                           ocupado;
  logic                           pronto;
  logic                           tick;
  logic                           clr_baud;

  logic [CNT_W-1:0]     num_clamp;
  logic [CNT_W-1:0]     prox_idx;
  logic [DATA_BITS-1:0] char0;
  logic [DATA_BITS-1:0] prox_char;

  // Clamp the requested count and select the character that follows the current one.
  always_comb begin
    num_clamp = bus.num_caracteres;
    if (bus.num_caracteres > CNT_W'(NUM_CHARS)) num_clamp = CNT_W'(NUM_CHARS);
    prox_idx  = CNT_W'(indice) + CNT_W'(1);
    char0     = bus.dados_ascii[DATA_BITS-1:0];
    prox_char = '0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (prox_idx == CNT_W'(k)) prox_char = buffer[k*DATA_BITS +: DATA_BITS];
    end
  end

  // The baud counter only runs while a bit is on the line; it wraps exactly at
  // each bit boundary, so it restarts at 0 for every new bit.
  assign clr_baud = (estado == OCIOSO) || (estado == FINAL);

  contador_m #(.M(CLKS_PER_BIT)) u_baud (
    .clock (clock),
    .reset (reset),
    .clr   (clr_baud),
    .en    (!clr_baud),
    .fim   (tick)
  );

  // Frame sequencer: state, shift register, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      buffer   <= '0;
      shift    <= '0;
      paridade <= 1'b0;
      total    <= '0;
      indice   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      saida    <= 1'b1;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            buffer   <= bus.dados_ascii;
            total    <= num_clamp;
            indice   <= '0;
            shift    <= char0;
            paridade <= calc_paridade(8'(char0), IMPAR);
            if (num_clamp != '0) begin
              estado  <= INICIO;
              saida   <= 1'b0;
              ocupado <= 1'b1;
            end else begin
              estado <= FINAL;
              pronto <= 1'b1;
            end
          end
        end
        INICIO: begin
          if (tick) begin
            estado  <= DADOS;
            saida   <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
        end
        DADOS: begin
          if (tick) begin
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                estado <= PARIDADE;
                saida  <= paridade;
              end else begin
                estado   <= PARADA;
                saida    <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              saida   <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        PARIDADE: begin
          if (tick) begin
            estado   <= PARADA;
            saida    <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        PARADA: begin
          if (tick) begin
            if (STOP_BITS == 2 && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else if (prox_idx < total) begin
              estado   <= INICIO;
              saida    <= 1'b0;
              indice   <= IDX_W'(prox_idx);
              shift    <= prox_char;
              paridade <= calc_paridade(8'(prox_char), IMPAR);
            end else begin
              estado  <= FINAL;
              saida   <= 1'b1;
              ocupado <= 1'b0;
              pronto  <= 1'b1;
            end
          end
        end
        FINAL:   estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.saida_serial     = saida;
  assign bus.ocupado          = ocupado;
  assign bus.pronto           = pronto;
  assign bus.indice_caractere = indice;
  assign bus.estado           = estado;
endmodule

// File: tb/tb_transmissor_ascii_param.sv
// Bench for transmissor_ascii_param: three parameter sets against a bit-list line model.
module tb_transmissor_ascii_param;
  import transmissor_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Per-instance configuration: 0 = even/2 stop, 1 = no parity/1 stop, 2 = odd/1 stop.
  int cfg_nc[3]    = '{4, 4, 2};
  int cfg_clks[3]  = '{4, 3, 2};
  int cfg_paren[3] = '{1, 0, 1};
  int cfg_odd[3]   = '{PARIDADE_PAR, PARIDADE_PAR, PARIDADE_IMPAR};
  int cfg_stop[3]  = '{2, 1, 1};

  transmissor_ascii_param_if #(.NUM_CHARS(4), .DATA_BITS(7)) ifa ();
  transmissor_ascii_param_if #(.NUM_CHARS(4), .DATA_BITS(7)) ifb ();
  transmissor_ascii_param_if #(.NUM_CHARS(2), .DATA_BITS(7)) ifc ();

  transmissor_ascii_param #(.NUM_CHARS(4), .DATA_BITS(7), .CLKS_PER_BIT(4),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_a (
    .clock(clk), .reset(rst_n), .bus(ifa.slave));
  transmissor_ascii_param #(.NUM_CHARS(4), .DATA_BITS(7), .CLKS_PER_BIT(3),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clock(clk), .reset(rst_n), .bus(ifb.slave));
  transmissor_ascii_param #(.NUM_CHARS(2), .DATA_BITS(7), .CLKS_PER_BIT(2),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clock(clk), .reset(rst_n), .bus(ifc.slave));

  // Expected {saida_serial, ocupado, pronto} per cycle, and expected index (-1 = don't care).
  logic [2:0] exp_q[$];
  int         exp_idx_q[$];

  task automatic drive(input int inst, input logic ini, input logic [27:0] d, input int n);
    case (inst)
      0: begin ifa.iniciar = ini; ifa.dados_ascii = d; ifa.num_caracteres = 3'(n); end
      1: begin ifb.iniciar = ini; ifb.dados_ascii = d; ifb.num_caracteres = 3'(n); end
      default: begin ifc.iniciar = ini; ifc.dados_ascii = d[13:0]; ifc.num_caracteres = 2'(n); end
    endcase
  endtask

  task automatic sample(input int inst, output logic [2:0] o, output int idx);
    case (inst)
      0: begin o = {ifa.saida_serial, ifa.ocupado, ifa.pronto}; idx = int'(ifa.indice_caractere); end
      1: begin o = {ifb.saida_serial, ifb.ocupado, ifb.pronto}; idx = int'(ifb.indice_caractere); end
      default: begin o = {ifc.saida_serial, ifc.ocupado, ifc.pronto}; idx = int'(ifc.indice_caractere); end
    endcase
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {saida,ocupado,pronto}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Line model: each character is a list of frame bits, each held CLKS cycles,
  // followed by the pronto cycle and one idle cycle.
  task automatic build_expected(input int inst, input logic [27:0] d, input int n);
    int         ne;
    int         fb;
    logic [6:0] c;
    logic       b;
    logic       p;
    exp_q.delete();
    exp_idx_q.delete();
    ne = (n > cfg_nc[inst]) ? cfg_nc[inst] : n;
    fb = frame_bits(7, cfg_paren[inst], cfg_stop[inst]);
    for (int k = 0; k < ne; k++) begin
      c = d[k*7 +: 7];
      p = ($countones(c) % 2) == 1;
      if (cfg_odd[inst] == PARIDADE_IMPAR) p = !p;
      for (int i = 0; i < fb; i++) begin
        if (i == 0) b = 1'b0;
        else if (i <= 7) b = c[i-1];
        else if (cfg_paren[inst] == 1 && i == 8) b = p;
        else b = 1'b1;
        for (int r = 0; r < cfg_clks[inst]; r++) begin
          exp_q.push_back({b, 1'b1, 1'b0});
          exp_idx_q.push_back(k);
        end
      end
    end
    exp_q.push_back(3'b101);
    exp_idx_q.push_back(-1);
    exp_q.push_back(3'b100);
    exp_idx_q.push_back(-1);
  endtask

  // Start a transmission and compare every following cycle; at cycle poke_at
  // (if >= 0) new data and a second iniciar are driven mid-transmission.
  task automatic run_tx(input int inst, input logic [27:0] d, input int n,
                        input string tag, input int poke_at);
    logic [2:0]  o;
    int          idx;
    logic [27:0] cur_d;
    int          cur_n;
    cur_d = d;
    cur_n = n;
    build_expected(inst, d, n);
    @(negedge clk);
    drive(inst, 1'b1, d, n);
    @(posedge clk);
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      sample(inst, o, idx);
      check3($sformatf("%s line c%0d", tag, j), o, exp_q[j]);
      if (exp_idx_q[j] >= 0) check_int($sformatf("%s indice c%0d", tag, j), idx, exp_idx_q[j]);
      if (j == poke_at) begin
        cur_d = 28'($urandom);
        cur_n = $urandom_range(1, 3);
        drive(inst, 1'b1, cur_d, cur_n);
      end else begin
        drive(inst, 1'b0, cur_d, cur_n);
      end
    end
  endtask

  initial begin : stimulus
    logic [2:0]  o;
    int          idx;
    logic [27:0] d;
    int          inst;
    int          n;

    // Reset state of all three instances.
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample(i, o, idx);
      check3($sformatf("reset u%0d", i), o, 3'b100);
      check_int($sformatf("reset indice u%0d", i), idx, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 'A', even parity, two stop bits.
    run_tx(0, 28'h41, 1, "char_A", -1);
    // "OK\n", no parity, one stop bit, contiguous frames.
    run_tx(1, {7'h00, 7'h0A, 7'h4B, 7'h4F}, 3, "ok_nl", -1);
    // Odd parity on 0x00 and even parity on 0x7F.
    run_tx(2, 28'h00, 1, "odd_00", -1);
    run_tx(0, 28'h7F, 1, "even_7f", -1);
    // Empty block and over-range count.
    run_tx(0, 28'($urandom), 0, "zero", -1);
    run_tx(0, 28'($urandom), 7, "clamp", -1);
    // Input changes and a second iniciar mid-transmission.
    run_tx(0, 28'($urandom), 2, "poke", 30);

    // Reset during data bit 3 of char 1 (cycles t+61..t+64 for instance 0).
    d = 28'($urandom);
    @(negedge clk);
    drive(0, 1'b1, d, 2);
    @(posedge clk);
    for (int j = 0; j < 61; j++) begin
      @(negedge clk);
      drive(0, 1'b0, d, 2);
    end
    sample(0, o, idx);
    check3("pre_reset bit3", o, {d[10], 1'b1, 1'b0});
    #1 rst_n = 1'b0;
    #1 sample(0, o, idx);
    check3("async_reset", o, 3'b100);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      sample(0, o, idx);
      check3($sformatf("in_reset c%0d", j), o, 3'b100);
    end
    rst_n = 1'b1;
    @(negedge clk);
    sample(0, o, idx);
    check3("after_reset idle", o, 3'b100);
    run_tx(0, 28'($urandom), 1, "post_reset", -1);

    // Randomized blocks across all configurations.
    for (int r = 0; r < 8; r++) begin
      inst = $urandom_range(0, 2);
      n    = $urandom_range(0, cfg_nc[inst] + 1);
      d    = 28'($urandom);
      run_tx(inst, d, n, $sformatf("rand%0d", r), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
